cordic_stream_controller: RTL and testbench
===========================================

Name: cordic_stream_controller

Overview:
- Valid/ready streaming front- and back-end that wraps the combinational-mode, fixed-latency CORDIC_Rotation pipeline.
- Registers requests into the core and tracks each one through the core's latency with a valid/tag shift register.
- Captures results into a result FIFO and presents them downstream with backpressure.
- Uses a credit scheme so nothing is lost, since the core cannot stall, and drains the pipeline before any mode change, since the core's mode input is shared by all stages.

Parameters:
- CORDIC_LATENCY, 28, registered stages in the core (NUMBER_OF_ITERATIONS-1).
- FIFO_DEPTH, 32, result FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the user tag carried alongside each request.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at the edge.
- in_x  in  32  signed x.
- in_y  in  32  signed y.
- in_angle  in  32  signed angle; 2^28 = 45 deg.
- in_mode  in  2  00 LINEAR, 10 CIRCULAR, 11 HYPERBOLIC, 01 illegal.
- in_tag  in  TAG_W  user tag.
- core_x, core_y, core_angle  out  32 each  registered operands to the core.
- core_mode  out  2  registered mode, held constant while anything is in flight.
- core_rx, core_ry, core_rangle  in  32 each  core results (rotated_x, rotated_y, final_angle).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_x, out_y, out_angle  out  32 each  result data.
- out_tag  out  TAG_W  tag of the request.
- out_err  out  1  request used illegal mode 01.
- busy  out  1  inflight != 0 or FIFO not empty.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - in_ready=0, out_valid=0, busy=0.
  - core_x/y/angle=0, core_mode=2'b10 (CIRCULAR).
  - Shift register, inflight counter and FIFO pointers/count cleared.
  - Reset mid-operation discards all in-flight and queued results; no partial output after release.
- Credit: in_ready = !reset & (inflight + fifo_count < FIFO_DEPTH) & mode_ok.
  - mode_ok = (in_mode == core_mode) | (inflight == 0).
  - in_ready may depend combinationally on in_mode; no other combinational path from inputs to in_ready.
- Accept at edge E:
  - core_x/y/angle/mode load the inputs.
  - Bit 0 of the valid shift register is set with {tag, err = (in_mode==01)}.
  - inflight increments.
- Mode 01 is passed to the core unchanged; the result is captured normally with out_err=1.
- The shift register is CORDIC_LATENCY+1 deep and aligned with the core.
  - At edge E+1+CORDIC_LATENCY the core outputs for that request are written to the FIFO and inflight decrements.
  - With default parameters and an empty FIFO, out_valid rises after edge E+29.
- Same-edge accept and capture: inflight unchanged.
- Same-edge FIFO write and pop: fifo_count unchanged.
- Mode switch:
  - A request whose mode differs from core_mode stalls (in_ready=0) until inflight==0.
  - It is accepted on the first cycle the pipeline is empty; FIFO contents need not be drained.
- core_mode changes only on an accepted request.
- No back-to-back restrictions otherwise; throughput 1 request per cycle.
- FIFO:
  - First-word-fall-through; out_* show the head whenever out_valid=1.
  - Pop on out_valid & out_ready.
  - The credit rule guarantees no write when full; overflow is an assertion failure.
- Order: results leave in acceptance order.
- out_* hold stable while out_valid & !out_ready.
- Counter widths: inflight 0..CORDIC_LATENCY+1; fifo_count 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared CONSTANTS header, reused (no new package): LINEAR/CIRCULAR/HYPERBOLIC mode encodings; new MODE_ILLEGAL = 2'b01 added there.
- Sub-module cordic_result_fifo:
  - Parameters: width 96+TAG_W+1, depth FIFO_DEPTH.
  - Ports: wr_en, rd_en, full, empty, count.
- The top-level wrapper instantiating both this block and the core is separate and out of scope.

Test Plan:
- Single op: reset, then one CIRCULAR request with x=0x20000000, y=0, angle=0x10000000, tag=5 and out_ready=1 -> out_valid rises exactly 29 cycles after acceptance; out_tag=5, out_err=0; data bit-exact to the golden core model; busy falls one cycle after the pop.
- Streaming: 100 back-to-back CIRCULAR requests, tags 0..15 cycling, out_ready=1 -> in_ready never drops; 100 results in order, one per cycle from cycle 29.
- Backpressure: out_ready=0, 40 requests offered -> exactly 32 accepted, in_ready low thereafter; out_ready=1 -> 32 results in order, then remaining 8 accepted.
- Mode switch: CIRCULAR request at cycle 0, HYPERBOLIC offered at cycle 1 -> HYPERBOLIC held off until inflight==0 (accepted at cycle 29); core_mode changes 10->11 only then; both results correct.
- Illegal mode: request with in_mode=01, tag=3 -> accepted; result emerges with out_err=1, tag=3; following legal requests unaffected.
- Reset mid-op: 10 requests in flight and 5 queued, reset pulsed asynchronously mid-cycle -> outputs go to reset values immediately; no out_valid after release until new requests are accepted.

Source files
------------

// File: rtl/cordic_stream_controller_pkg.sv
// Shared CORDIC constants: mode encodings understood by the rotation core.
// MODE_ILLEGAL is passed through to the core but flagged on the result.
package cordic_stream_controller_pkg;

    typedef enum logic [1:0] {
        MODE_LINEAR     = 2'b00,
        MODE_ILLEGAL    = 2'b01,
        MODE_CIRCULAR   = 2'b10,
        MODE_HYPERBOLIC = 2'b11
    } cordic_mode_e;

    localparam int CORE_DATA_W = 96;

    function automatic logic is_illegal_mode(input logic [1:0] mode);
        return mode == MODE_ILLEGAL;
    endfunction

endpackage

// File: rtl/cordic_stream_controller_result_fifo.sv
// First-word-fall-through result FIFO; the head is visible on rd_data whenever !empty.
// Writes while full are dropped and flagged by assertion; the upstream credit scheme prevents them.
module cordic_result_fifo #(
    parameter int WIDTH = 101,
    parameter int DEPTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(wr_en && full));
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cordic_stream_controller.sv
// Valid/ready wrapper around the non-stallable CORDIC pipeline: registers operands,
// tracks requests with a valid/tag shift register, and buffers results under a credit scheme.
module cordic_stream_controller
    import cordic_stream_controller_pkg::*;
#(
    parameter int CORDIC_LATENCY = 28,
    parameter int FIFO_DEPTH     = 32,
    parameter int TAG_W          = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_x,
    input  logic [31:0]       in_y,
    input  logic [31:0]       in_angle,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [31:0]       core_x,
    output logic [31:0]       core_y,
    output logic [31:0]       core_angle,
    output logic [1:0]        core_mode,
    input  logic [31:0]       core_rx,
    input  logic [31:0]       core_ry,
    input  logic [31:0]       core_rangle,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_x,
    output logic [31:0]       out_y,
    output logic [31:0]       out_angle,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic              busy
);
    localparam int INF_W   = $clog2(CORDIC_LATENCY + 2);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W   = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;
    localparam int ENTRY_W = CORE_DATA_W + TAG_W + 1;
    localparam int LAST    = CORDIC_LATENCY;

    logic [INF_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [SUM_W-1:0]   credit_used;
    logic               fifo_full;
    logic               fifo_empty;
    logic               mode_ok;
    logic               accept;
    logic               capture;
    logic               pop;
    logic [LAST:0]      sr_valid;
    logic [LAST:0]      sr_err;
    logic [TAG_W-1:0]   sr_tag [LAST+1];
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_data;

    // The core's mode is shared by every stage, so a new mode waits for an empty pipeline.
    assign mode_ok     = (in_mode == core_mode) || (inflight == '0);
    assign credit_used = SUM_W'(inflight) + SUM_W'(fifo_count);
    assign in_ready    = !reset && mode_ok && !fifo_full && (credit_used < SUM_W'(FIFO_DEPTH));
    assign accept      = in_valid && in_ready;
    assign capture     = sr_valid[LAST];
    assign pop         = out_valid && out_ready;
    assign wr_data     = {sr_tag[LAST], sr_err[LAST], core_rx, core_ry, core_rangle};
    assign out_valid   = !fifo_empty;
    assign busy        = (inflight != '0) || !fifo_empty;
    assign {out_tag, out_err, out_x, out_y, out_angle} = rd_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            core_x     <= '0;
            core_y     <= '0;
            core_angle <= '0;
            core_mode  <= MODE_CIRCULAR;
        end else if (accept) begin
            core_x     <= in_x;
            core_y     <= in_y;
            core_angle <= in_angle;
            core_mode  <= in_mode;
        end
    end

    // Stage k of the shift register lines up with the request k edges after acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr_valid <= '0;
            sr_err   <= '0;
            for (int i = 0; i <= LAST; i++) sr_tag[i] <= '0;
        end else begin
            sr_valid  <= {sr_valid[LAST-1:0], accept};
            sr_err    <= {sr_err[LAST-1:0], accept && is_illegal_mode(in_mode)};
            sr_tag[0] <= in_tag;
            for (int i = 1; i <= LAST; i++) sr_tag[i] <= sr_tag[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({accept, capture})
                2'b10:   inflight <= inflight + INF_W'(1);
                2'b01:   inflight <= inflight - INF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    cordic_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_cordic_stream_controller.sv
// Bench for cordic_stream_controller: behavioural core stand-in, scoreboard queue,
// table-driven vectors and hand-written timing/backpressure/reset sequences.
module tb_cordic_stream_controller;
    localparam int L     = 28;
    localparam int DEPTH = 32;
    localparam int TW    = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_x, in_y, in_angle;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag;
    logic [31:0]   core_x, core_y, core_angle;
    logic [1:0]    core_mode;
    logic [31:0]   core_rx, core_ry, core_rangle;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_x, out_y, out_angle;
    logic [TW-1:0] out_tag;
    logic          out_err;
    logic          busy;

    cordic_stream_controller #(
        .CORDIC_LATENCY (L),
        .FIFO_DEPTH     (DEPTH),
        .TAG_W          (TW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_angle    (in_angle),
        .in_mode     (in_mode),
        .in_tag      (in_tag),
        .core_x      (core_x),
        .core_y      (core_y),
        .core_angle  (core_angle),
        .core_mode   (core_mode),
        .core_rx     (core_rx),
        .core_ry     (core_ry),
        .core_rangle (core_rangle),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_angle   (out_angle),
        .out_tag     (out_tag),
        .out_err     (out_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Core stand-in: operands travel L registers; the shared mode is applied at the output,
    // so a mode change while anything is in flight corrupts the result.
    function automatic logic [95:0] core_f(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] a, input logic [1:0] m);
        logic [31:0] rx, ry, ra;
        rx = x + {a[15:0], y[15:0]};
        ry = y ^ (x >> 3) ^ {30'd0, m};
        ra = a - x + {30'd0, m};
        return {rx, ry, ra};
    endfunction

    logic [31:0] px [L];
    logic [31:0] py [L];
    logic [31:0] pa [L];
    always @(posedge clock) begin
        px[0] <= core_x;
        py[0] <= core_y;
        pa[0] <= core_angle;
        for (int i = 1; i < L; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign {core_rx, core_ry, core_rangle} = core_f(px[L-1], py[L-1], pa[L-1], core_mode);

    typedef struct packed {
        logic [TW-1:0] tag;
        logic          err;
        logic [31:0]   x;
        logic [31:0]   y;
        logic [31:0]   a;
    } exp_t;

    typedef struct {
        logic [31:0]   x, y, a;
        logic [1:0]    mode;
        logic [TW-1:0] tag;
        logic          err;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pop_cnt = 0;
    int   first_pop_cyc = 0;
    int   last_pop_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] x, input logic [31:0] y, input logic [31:0] a,
                            input logic [1:0] m, input logic [TW-1:0] t, input logic err);
        exp_t e;
        e.tag = t;
        e.err = err;
        {e.x, e.y, e.a} = core_f(x, y, a, m);
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got tag %0h with nothing pending", out_tag);
            end else begin
                e = sb.pop_front();
                check("result", {out_tag, out_err, out_x, out_y, out_angle}, e);
            end
            if (pop_cnt == 0) first_pop_cyc = cyc;
            pop_cnt++;
            last_pop_cyc = cyc;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    // acc_cyc is the edge count seen just before the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] a,
                        input logic [1:0] m, input logic [TW-1:0] t, input logic err,
                        output int acc_cyc, output int stalls);
        in_x = x; in_y = y; in_angle = a; in_mode = m; in_tag = t;
        in_valid = 1'b1;
        stalls = 0;
        acc_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (in_ready) begin
                push_exp(x, y, a, m, t, err);
                acc_cyc = cyc;
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                return;
            end
            stalls++;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        check("send_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) break;
        end
        check(name, {sb.size(), 31'd0, busy}, 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    vec_t        tbl [8];
    int          acc, acc1, acc2, st, stall_sum, first_acc, rise, nacc, idx;
    logic [100:0] held;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_angle = '0;
        in_mode = 2'b10; in_tag = '0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_core_mode", core_mode, 2'b10);
        check("rst_core_ops", {core_x, core_y, core_angle}, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", in_ready, 1);
        @(posedge clock); #1;

        // Single op: out_valid visible after edge E+29; E = acc+1, so observed at cyc acc+30.
        send(32'h2000_0000, 32'h0, 32'h1000_0000, 2'b10, 4'd5, 1'b0, acc, st);
        rise = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (out_valid) begin rise = cyc; break; end
        end
        check("single_latency", rise - acc, L + 2);
        check("single_tag_err", {out_tag, out_err}, {4'd5, 1'b0});
        check("single_busy_before_pop", busy, 1);
        @(negedge clock);
        check("single_busy_after_pop", {busy, out_valid}, 0);
        check("single_sb_empty", sb.size(), 0);
        @(posedge clock); #1;

        // Streaming: 100 back-to-back, one result per cycle.
        pop_cnt = 0; stall_sum = 0; first_acc = 0;
        for (int i = 0; i < 100; i++) begin
            send(32'h0101_0101 * i + 7, 32'hdead_0000 ^ i, 32'h0100_0000 + i * 3, 2'b10,
                 TW'(i % 16), 1'b0, acc, st);
            if (i == 0) first_acc = acc;
            stall_sum += st;
        end
        drain("stream_drain");
        check("stream_no_stall", stall_sum, 0);
        check("stream_count", pop_cnt, 100);
        check("stream_contiguous", last_pop_cyc - first_pop_cyc, 99);
        check("stream_first_latency", first_pop_cyc - first_acc, L + 2);

        // Mode switch: capture at E+L+1 clears inflight; the new mode is accepted on the next edge.
        send(32'h1234_5678, 32'h0bad_beef, 32'h0800_0000, 2'b10, 4'd1, 1'b0, acc1, st);
        check("mode_circ_loaded", core_mode, 2'b10);
        send(32'h0765_4321, 32'h0000_1111, 32'h0400_0000, 2'b11, 4'd2, 1'b0, acc2, st);
        check("mode_switch_wait", acc2 - acc1, L + 2);
        check("mode_hyp_loaded", core_mode, 2'b11);
        drain("mode_drain");

        // Table-driven mixed modes including the illegal encoding.
        tbl[0] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_0300, 2'b00, 4'd0, 1'b0};
        tbl[1] = '{32'h4000_0000, 32'h0000_0000, 32'h1000_0000, 2'b10, 4'd7, 1'b0};
        tbl[2] = '{32'h3000_0000, 32'h1000_0000, 32'hf000_0000, 2'b10, 4'd8, 1'b0};
        tbl[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 2'b01, 4'd3, 1'b1};
        tbl[4] = '{32'h2000_0000, 32'h0000_0000, 32'h0800_0000, 2'b11, 4'd9, 1'b0};
        tbl[5] = '{32'hffff_0000, 32'h0000_ffff, 32'h8000_0001, 2'b11, 4'd15, 1'b0};
        tbl[6] = '{32'h7fff_ffff, 32'h8000_0000, 32'h0000_0000, 2'b00, 4'd4, 1'b0};
        tbl[7] = '{32'h2000_0000, 32'h0000_0000, 32'h1000_0000, 2'b10, 4'd12, 1'b0};
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].mode, tbl[i].tag, tbl[i].err, acc, st);
        end
        drain("table_drain");

        // Backpressure: credit limits acceptance to FIFO_DEPTH while nothing is popped.
        out_ready = 1'b0; nacc = 0; idx = 0; in_mode = 2'b10;
        for (int k = 0; k < 80; k++) begin
            in_valid = 1'b1;
            in_x = 32'h0100_0000 + idx; in_y = 32'h55 * idx; in_angle = 32'h0200_0000 - idx;
            in_tag = TW'(idx);
            @(negedge clock);
            if (in_ready) begin
                push_exp(in_x, in_y, in_angle, in_mode, in_tag, 1'b0);
                nacc++; idx++;
            end
            @(posedge clock); #1;
        end
        check("bp_accepted", nacc, DEPTH);
        @(negedge clock);
        check("bp_ready_low", in_ready, 0);
        held = {out_tag, out_err, out_x, out_y, out_angle};
        repeat (3) @(negedge clock);
        check("bp_hold_stable", {out_valid, out_tag, out_err, out_x, out_y, out_angle}, {1'b1, held});
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && idx < 40; k++) begin
            in_valid = 1'b1;
            in_x = 32'h0100_0000 + idx; in_y = 32'h55 * idx; in_angle = 32'h0200_0000 - idx;
            in_tag = TW'(idx);
            @(negedge clock);
            if (in_ready) begin
                push_exp(in_x, in_y, in_angle, in_mode, in_tag, 1'b0);
                nacc++; idx++;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        check("bp_total", nacc, 40);
        drain("bp_drain");

        // Reset mid-op: 5 queued in the FIFO, 10 in flight, reset asserted mid-cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h0a00_0000 + i, 32'h1, 32'h2, 2'b11, TW'(i), 1'b0, acc, st);
        repeat (32) @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) send(32'h0b00_0000 + i, 32'h3, 32'h4, 2'b11, TW'(i), 1'b0, acc, st);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_outputs", {out_valid, in_ready, busy}, 0);
        check("midrst_core", {core_mode, core_x, core_y, core_angle}, {2'b10, 96'd0});
        sb.delete();
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        pop_cnt = 0;
        repeat (40) @(negedge clock);
        check("midrst_no_output", {pop_cnt, busy}, 0);
        @(posedge clock); #1;
        send(32'h0c00_0000, 32'h5, 32'h6, 2'b10, 4'd6, 1'b0, acc, st);
        drain("post_reset_drain");
        check("post_reset_count", pop_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
